radix3_bfly27_s1: RTL
=====================

Name: radix3_bfly27_s1

Overview:
- First butterfly stage of the 27-point FFT. It sits directly downstream of the base-3 digit-reversal reorder block and consumes that block's serial 27-sample burst.
- It groups each run of 3 consecutive accepted samples into a triple (a, b, c) and computes the twiddle-free radix-3 DFT of the triple.
- It streams X0, X1, X2 out serially, one per cycle, to the next (twiddled) stage.
- It also flags the 27th output of each frame.

Parameters:
- WIDTH, 18: input sample width per component, signed two's complement.
- COEF_W, 16: width of the sqrt(3)/2 constant, signed Q1.(COEF_W-1).
- K_SQ3, 28378: round(0.8660254 * 2^(COEF_W-1)). Must be consistent with COEF_W.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets)
- di_re  input  WIDTH  signed input real
- di_im  input  WIDTH  signed input imaginary
- di_en  input  1  input sample valid; one sample accepted per cycle when high
- do_re  output  WIDTH+2  signed butterfly output real (registered)
- do_im  output  WIDTH+2  signed butterfly output imaginary (registered)
- do_en  output  1  output valid
- do_last  output  1  high with the 27th output of a frame

Behaviour:
- Reset (rst==0 at an edge):
  - do_re, do_im, do_en, do_last are all 0.
  - Triple index (0..2), output phase (0..2), frame output counter (0..26) and results-valid flag are cleared.
  - Partial triples and pending results are discarded.
- Input capture:
  - On each edge with di_en=1, the sample is stored as a, b or c according to the triple index, and the index advances 0->1->2->0.
  - di_en=0 holds all input state. Gaps of any length are legal, both inside and between triples.
- Compute:
  - The edge after c is captured, register X0, X1 and X2 from a, b, c and set results-valid.
  - Let s=b+c and d=b-c, componentwise at WIDTH+1 bits.
  - Let h=s>>>1 (arithmetic, floor).
  - Let m_re=(K_SQ3*d_re)>>>(COEF_W-1) and m_im=(K_SQ3*d_im)>>>(COEF_W-1). Both are full-precision products floored by the arithmetic shift; no rounding.
  - X0 = a+s
  - X1re = a_re-h_re+m_im; X1im = a_im-h_im-m_re
  - X2re = a_re-h_re-m_im; X2im = a_im-h_im+m_re
  - All sums are computed at WIDTH+2 bits. No saturation is needed: |X| <= 3*2^(WIDTH-1).
- Output sequencing:
  - If c is sampled at edge n, the block drives do_en=1 with X0 after edge n+2, X1 after n+3 and X2 after n+4.
  - Otherwise do_en=0 and do_re=do_im=0.
- Throughput:
  - Input arrives at most 1 sample/cycle, so consecutive c captures are at least 3 edges apart and the output never overlaps.
  - A back-to-back 27-sample input burst yields a contiguous 27-cycle do_en burst.
  - At edge n+4 the result registers may be overwritten by the next triple while X2 is being launched. X2 must come from the old values (nonblocking semantics).
- Frame tracking:
  - The frame counter increments on every do_en output and wraps 26->0.
  - do_last=1 exactly when the output with count 26 is driven.
  - The counter is not re-synchronised except by reset.
- Simultaneous events: di_en during output of the previous triple is normal operation and must not stall or corrupt either stream.
- Reset mid-operation: takes precedence over di_en and over output in progress. The first triple after reset starts at index 0.

Test Plan:
- Reset check: hold rst=0 for 3 cycles while di_en=1 -> do_en=0, do_last=0, do_re=do_im=0 throughout.
- DC triple: a=100, b=0, c=0 (im 0) -> three outputs of 100+j0, first output 2 edges after c is sampled.
- Single b: a=0, b=1000+j0, c=0 -> X0=1000+j0, X1=-500-j866, X2=-500+j866.
- Full scale (WIDTH=18): a=b=c=131071+j0 -> X0=393213, X1=0+j0, X2=0+j0.
- Negative floor case: a=0, b=-3, c=0 -> h=-2, X1re=2, X1im=-floor(-3*28378/32768)=3.
- Burst 27 contiguous samples with values 1..27 (real) -> 27 contiguous do_en cycles, do_last only on the 27th. Each output triple matches the reference model, and the first output appears 2 edges after the 3rd input.
- Gapped input: di_en toggled 1,0,0,1,0,1 -> one triple output, correct values.
- Reset mid-triple: after 2 samples, rst=0 one cycle, then new triple 7, 8, 9 -> only the new triple's outputs (X0=24) appear.

Source files
------------

// File: rtl/radix3_bfly27_s1.sv
// First radix-3 butterfly stage of the 27-point FFT.
// Collects sample triples, computes the twiddle-free 3-point DFT, streams X0/X1/X2.
module radix3_bfly27_s1 #(
    parameter int WIDTH  = 18,
    parameter int COEF_W = 16,
    parameter int K_SQ3  = 28378
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic                    di_en,
    output logic signed [WIDTH+1:0] do_re,
    output logic signed [WIDTH+1:0] do_im,
    output logic                    do_en,
    output logic                    do_last
);

    localparam int SW = WIDTH + 1;
    localparam int OW = WIDTH + 2;
    localparam int PW = COEF_W + WIDTH + 1;
    localparam logic signed [COEF_W-1:0] KC = COEF_W'(K_SQ3);

    logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im, c_re, c_im;
    logic [1:0]              idx;
    logic                    cv;

    logic signed [OW-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
    logic                 rv;
    logic [1:0]           ph;
    logic [4:0]           cnt;

    logic signed [SW-1:0] s_re, s_im, d_re, d_im;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [OW-1:0] m_re, m_im, h_re, h_im;
    logic signed [OW-1:0] ax_re, ax_im, sx_re, sx_im;
    logic signed [OW-1:0] n0_re, n0_im, n1_re, n1_im, n2_re, n2_im;

    assign s_re = {b_re[WIDTH-1], b_re} + {c_re[WIDTH-1], c_re};
    assign s_im = {b_im[WIDTH-1], b_im} + {c_im[WIDTH-1], c_im};
    assign d_re = {b_re[WIDTH-1], b_re} - {c_re[WIDTH-1], c_re};
    assign d_im = {b_im[WIDTH-1], b_im} - {c_im[WIDTH-1], c_im};

    // Exact product; the upper slice is the floored arithmetic shift.
    assign p_re = {{(PW-COEF_W){KC[COEF_W-1]}}, KC}
                * {{(PW-SW){d_re[SW-1]}}, d_re};
    assign p_im = {{(PW-COEF_W){KC[COEF_W-1]}}, KC}
                * {{(PW-SW){d_im[SW-1]}}, d_im};
    assign m_re = p_re[PW-1:COEF_W-1];
    assign m_im = p_im[PW-1:COEF_W-1];

    assign h_re  = {{2{s_re[SW-1]}}, s_re[SW-1:1]};
    assign h_im  = {{2{s_im[SW-1]}}, s_im[SW-1:1]};
    assign ax_re = {{2{a_re[WIDTH-1]}}, a_re};
    assign ax_im = {{2{a_im[WIDTH-1]}}, a_im};
    assign sx_re = {s_re[SW-1], s_re};
    assign sx_im = {s_im[SW-1], s_im};

    assign n0_re = ax_re + sx_re;
    assign n0_im = ax_im + sx_im;
    assign n1_re = ax_re - h_re + m_im;
    assign n1_im = ax_im - h_im - m_re;
    assign n2_re = ax_re - h_re - m_im;
    assign n2_im = ax_im - h_im + m_re;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx  <= 2'd0;
            cv   <= 1'b0;
            a_re <= '0;
            a_im <= '0;
            b_re <= '0;
            b_im <= '0;
            c_re <= '0;
            c_im <= '0;
        end else begin
            cv <= di_en && (idx == 2'd2);
            if (di_en) begin
                unique case (idx)
                    2'd0: begin
                        a_re <= di_re;
                        a_im <= di_im;
                    end
                    2'd1: begin
                        b_re <= di_re;
                        b_im <= di_im;
                    end
                    default: begin
                        c_re <= di_re;
                        c_im <= di_im;
                    end
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    // A new triple may land on the same edge that launches X2 of the old one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rv      <= 1'b0;
            ph      <= 2'd0;
            cnt     <= 5'd0;
            x0_re   <= '0;
            x0_im   <= '0;
            x1_re   <= '0;
            x1_im   <= '0;
            x2_re   <= '0;
            x2_im   <= '0;
            do_re   <= '0;
            do_im   <= '0;
            do_en   <= 1'b0;
            do_last <= 1'b0;
        end else begin
            if (rv) begin
                do_en   <= 1'b1;
                do_last <= (cnt == 5'd26);
                cnt     <= (cnt == 5'd26) ? 5'd0 : cnt + 5'd1;
                unique case (ph)
                    2'd0: begin
                        do_re <= x0_re;
                        do_im <= x0_im;
                    end
                    2'd1: begin
                        do_re <= x1_re;
                        do_im <= x1_im;
                    end
                    default: begin
                        do_re <= x2_re;
                        do_im <= x2_im;
                    end
                endcase
                ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
                if (ph == 2'd2) rv <= 1'b0;
            end else begin
                do_en   <= 1'b0;
                do_last <= 1'b0;
                do_re   <= '0;
                do_im   <= '0;
            end
            if (cv) begin
                x0_re <= n0_re;
                x0_im <= n0_im;
                x1_re <= n1_re;
                x1_im <= n1_im;
                x2_re <= n2_re;
                x2_im <= n2_im;
                rv    <= 1'b1;
                ph    <= 2'd0;
            end
        end
    end

endmodule
